cvmcu_cpi_rx: RTL

- Chip-side receiver for the Camera Parallel Interface (CPI).
- Oversamples the camera pixel clock, VSYNC, HREF and the 8-bit data bus in the system clock domain.
- Assembles 8- or 16-bit pixels, buffers them in a small FIFO, and presents them on a valid/ready stream to the uDMA camera channel.
- Its counterpart is the CPI transmitter agent in the chip bench, which drives the camera pads.

---
 rtl/cvmcu_cpi_rx.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cvmcu_cpi_rx.sv
// Camera Parallel Interface receiver. Oversamples the camera pins in the
// ref_clk domain, assembles 8- or 16-bit pixels, buffers them in a small
// FIFO and presents them on a valid/ready stream with a start-of-frame tag.
module cvmcu_cpi_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int FCNT_W     = 16
) (
    input  logic              ref_clk_i,
    input  logic              rstn_i,
    input  logic              cam_pclk_i,
    input  logic              cam_vsync_i,
    input  logic              cam_href_i,
    input  logic [7:0]        cam_data_i,
    input  logic              en_i,
    input  logic              pix16_i,
    input  logic              clear_i,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic [15:0]       pix_data_o,
    output logic              pix_sof_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              overflow_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Synchroniser and pclk edge detector
    logic       pclk_s1_q, pclk_s1_d, pclk_s2_q, pclk_s2_d, pclk_prev_q, pclk_prev_d;
    logic       vsync_s1_q, vsync_s1_d, vsync_s2_q, vsync_s2_d;
    logic       href_s1_q, href_s1_d, href_s2_q, href_s2_d;
    logic [7:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic       pclk_rise_q, pclk_rise_d;

    // Capture FSM and pixel assembly
    logic [1:0]  state_q, state_d;
    logic        vsync_prev_q, vsync_prev_d;
    logic        pix16_q, pix16_d;
    logic [7:0]  msb_q, msb_d;
    logic        msb_pend_q, msb_pend_d;
    logic        push_q, push_d;
    logic [15:0] push_data_q, push_data_d;
    logic        frame_start, frame_end, err_set;

    // Status
    logic              sof_pend_q, sof_pend_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;
    logic              err_q, err_d;

    // FIFO: entries are {sof, data}
    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [16:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          fifo_empty, fifo_full, pop, wr_en, drop;

    // Two-flop synchronisers; the rise strobe is registered so every
    // capture decision sees a full cycle of stable synced pins.
    always_comb begin
        pclk_s1_d   = cam_pclk_i;
        pclk_s2_d   = pclk_s1_q;
        pclk_prev_d = pclk_s2_q;
        pclk_rise_d = pclk_s2_q & ~pclk_prev_q;
        vsync_s1_d  = cam_vsync_i;
        vsync_s2_d  = vsync_s1_q;
        href_s1_d   = cam_href_i;
        href_s2_d   = href_s1_q;
        data_s1_d   = cam_data_i;
        data_s2_d   = data_s1_q;
    end

    // Frame FSM: waits for a vsync falling sample, captures bytes while href
    // is high and finishes the frame on the next vsync high sample.
    always_comb begin
        state_d      = state_q;
        vsync_prev_d = vsync_prev_q;
        pix16_d      = pix16_q;
        msb_d        = msb_q;
        msb_pend_d   = msb_pend_q;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        err_set      = 1'b0;
        if (pclk_rise_q) begin
            vsync_prev_d = vsync_s2_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pix16_d = pix16_i;
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (pclk_rise_q && !vsync_s2_q && vsync_prev_q) begin
                    state_d     = ST_ACTIVE;
                    frame_start = 1'b1;
                    msb_pend_d  = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (pclk_rise_q) begin
                    if (!href_s2_q && msb_pend_q) begin
                        err_set    = 1'b1;
                        msb_pend_d = 1'b0;
                    end
                    if (vsync_s2_q) begin
                        frame_end  = 1'b1;
                        msb_pend_d = 1'b0;
                        state_d    = en_i ? ST_WAIT : ST_IDLE;
                    end else if (href_s2_q) begin
                        if (!pix16_q) begin
                            push_d      = 1'b1;
                            push_data_d = {8'h00, data_s2_q};
                        end else if (!msb_pend_q) begin
                            msb_d      = data_s2_q;
                            msb_pend_d = 1'b1;
                        end else begin
                            push_d      = 1'b1;
                            push_data_d = {msb_q, data_s2_q};
                            msb_pend_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel FIFO; a push into a full FIFO survives only if the head pops.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && pix_ready_i;
        wr_en      = push_q && (!fifo_full || pop);
        drop       = push_q && fifo_full && !pop;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = {sof_pend_q, push_data_q};
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Sticky flags, frame counter and sof tracking; clear beats any set.
    always_comb begin
        sof_pend_d  = sof_pend_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q | drop;
        err_d       = err_q | err_set;
        if (wr_en && sof_pend_q) begin
            sof_pend_d = 1'b0;
        end
        if (frame_start) begin
            sof_pend_d = 1'b1;
        end
        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
        if (clear_i) begin
            frame_cnt_d = '0;
            overflow_d  = 1'b0;
            err_d       = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge ref_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pclk_s1_q    <= 1'b0;
            pclk_s2_q    <= 1'b0;
            pclk_prev_q  <= 1'b0;
            pclk_rise_q  <= 1'b0;
            vsync_s1_q   <= 1'b0;
            vsync_s2_q   <= 1'b0;
            href_s1_q    <= 1'b0;
            href_s2_q    <= 1'b0;
            data_s1_q    <= '0;
            data_s2_q    <= '0;
            state_q      <= ST_IDLE;
            vsync_prev_q <= 1'b0;
            pix16_q      <= 1'b0;
            msb_q        <= '0;
            msb_pend_q   <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            sof_pend_q   <= 1'b0;
            frame_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pclk_s1_q    <= pclk_s1_d;
            pclk_s2_q    <= pclk_s2_d;
            pclk_prev_q  <= pclk_prev_d;
            pclk_rise_q  <= pclk_rise_d;
            vsync_s1_q   <= vsync_s1_d;
            vsync_s2_q   <= vsync_s2_d;
            href_s1_q    <= href_s1_d;
            href_s2_q    <= href_s2_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            state_q      <= state_d;
            vsync_prev_q <= vsync_prev_d;
            pix16_q      <= pix16_d;
            msb_q        <= msb_d;
            msb_pend_q   <= msb_pend_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            sof_pend_q   <= sof_pend_d;
            frame_cnt_q  <= frame_cnt_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
        end
    end

    assign pix_valid_o              = !fifo_empty;
    assign {pix_sof_o, pix_data_o}  = mem_q[rd_ptr_q[AW-1:0]];
    assign frame_cnt_o              = frame_cnt_q;
    assign overflow_o               = overflow_q;
    assign err_o                    = err_q;
    assign busy_o                   = (state_q == ST_ACTIVE);

endmodule
